// File: rtl/temp_poll_sequencer.sv
// Periodic 2-byte temperature poller driving a shared I2C master.
// Define TEMP_AVG_EN for a signed 4-sample moving average on temp_raw.
module temp_poll_sequencer #(
  parameter logic [6:0] SLAVE_ADDR     = 7'h4B,
  parameter int         POLL_CYCLES    = 50_000_000,
  parameter int         TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        run,
  output logic        i2c_ena,
  output logic [6:0]  i2c_addr,
  output logic        i2c_rw,
  input  logic        i2c_busy,
  input  logic [7:0]  i2c_data_rd,
  input  logic        i2c_ack_error,
  output logic [15:0] temp_raw,
  output logic        temp_valid,
  output logic        err
);

  localparam int PW = (POLL_CYCLES > 2) ? $clog2(POLL_CYCLES) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [PW-1:0] POLL_LOAD = PW'(POLL_CYCLES - 1);
  localparam logic [TW-1:0] TO_LOAD   = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, REQ, BYTE0, BYTE1, DONE, ABORT
  } state_t;

  state_t        r_state;
  logic          r_busy_q;
  logic [PW-1:0] r_poll;
  logic [TW-1:0] r_to;
  logic          r_ena;
  logic          r_err;
  logic [7:0]    r_msb;
  logic [7:0]    r_lsb;
  logic [15:0]   r_raw;
  logic          r_valid;

  logic w_busy_rise;
  logic w_busy_fall;
  logic w_to_zero;
  logic w_start;

  assign i2c_addr   = SLAVE_ADDR;
  assign i2c_rw     = 1'b1;
  assign i2c_ena    = r_ena;
  assign err        = r_err;
  assign temp_raw   = r_raw;
  assign temp_valid = r_valid;

  assign w_busy_rise = i2c_busy & ~r_busy_q;
  assign w_busy_fall = ~i2c_busy & r_busy_q;
  assign w_to_zero   = (r_to == '0);
  assign w_start     = (r_state == IDLE) && run && (r_poll == '0);

  // Previous busy level for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_busy_q <= 1'b0;
    else          r_busy_q <= i2c_busy;
  end

  // Poll interval timer: runs only while idle and enabled, reloads on start.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_poll <= POLL_LOAD;
    end else if (w_start) begin
      r_poll <= POLL_LOAD;
    end else if ((r_state == IDLE) && run) begin
      r_poll <= r_poll - 1'b1;
    end
  end

  // Transaction FSM with timeout watchdog; every state change reloads it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_to    <= TO_LOAD;
      r_ena   <= 1'b0;
      r_err   <= 1'b0;
      r_msb   <= '0;
      r_lsb   <= '0;
    end else begin
      r_to <= w_to_zero ? r_to : r_to - 1'b1;
      unique case (r_state)
        IDLE: begin
          if (w_start) begin
            r_state <= REQ;
            r_ena   <= 1'b1;
            r_to    <= TO_LOAD;
          end
        end
        REQ: begin
          if (i2c_ack_error || w_to_zero) begin
            r_state <= ABORT;
            r_ena   <= 1'b0;
            r_to    <= TO_LOAD;
          end else if (w_busy_rise) begin
            r_state <= BYTE0;
            r_to    <= TO_LOAD;
          end
        end
        BYTE0: begin
          if (i2c_ack_error || w_to_zero) begin
            r_state <= ABORT;
            r_ena   <= 1'b0;
            r_to    <= TO_LOAD;
          end else if (w_busy_rise) begin
            r_msb   <= i2c_data_rd;
            r_ena   <= 1'b0;
            r_state <= BYTE1;
            r_to    <= TO_LOAD;
          end
        end
        BYTE1: begin
          if (i2c_ack_error || w_to_zero) begin
            r_state <= ABORT;
            r_ena   <= 1'b0;
            r_to    <= TO_LOAD;
          end else if (w_busy_fall) begin
            r_lsb   <= i2c_data_rd;
            r_state <= DONE;
            r_to    <= TO_LOAD;
          end
        end
        DONE: begin
          r_err   <= 1'b0;
          r_state <= IDLE;
          r_to    <= TO_LOAD;
        end
        ABORT: begin
          if (w_to_zero || !i2c_busy) begin
            r_err   <= 1'b1;
            r_state <= IDLE;
            r_to    <= TO_LOAD;
          end
        end
        default: begin
          r_state <= IDLE;
          r_ena   <= 1'b0;
          r_to    <= TO_LOAD;
        end
      endcase
    end
  end

`ifdef TEMP_AVG_EN
  logic [15:0] r_hist [4];
  logic        r_primed;
  logic        r_pend;
  logic [17:0] w_sum;

  // Signed sum of the history window.
  always_comb begin
    w_sum = '0;
    for (int i = 0; i < 4; i++) begin
      w_sum = w_sum + {{2{r_hist[i][15]}}, r_hist[i]};
    end
  end

  // History update on DONE, then publish the average one edge later.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) r_hist[i] <= '0;
      r_primed <= 1'b0;
      r_pend   <= 1'b0;
      r_raw    <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_pend  <= 1'b0;
      r_valid <= 1'b0;
      if (r_state == DONE) begin
        if (!r_primed) begin
          for (int i = 0; i < 4; i++) r_hist[i] <= {r_msb, r_lsb};
          r_primed <= 1'b1;
        end else begin
          r_hist[0] <= {r_msb, r_lsb};
          for (int i = 1; i < 4; i++) r_hist[i] <= r_hist[i-1];
        end
        r_pend <= 1'b1;
      end
      if (r_pend) begin
        r_raw   <= w_sum[17:2];
        r_valid <= 1'b1;
      end
    end
  end
`else
  // Publish the assembled reading on the DONE edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_raw   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= (r_state == DONE);
      if (r_state == DONE) r_raw <= {r_msb, r_lsb};
    end
  end
`endif

endmodule

// File: tb/tb_temp_poll_sequencer.sv
// Scoreboard bench for temp_poll_sequencer with a small I2C master model.
// Compile with TEMP_AVG_EN defined to also exercise the averaging path.
module tb_temp_poll_sequencer;

  localparam int P = 100;
  localparam int T = 50;
`ifdef TEMP_AVG_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        run;
  logic        i2c_ena;
  logic [6:0]  i2c_addr;
  logic        i2c_rw;
  logic        i2c_busy;
  logic [7:0]  i2c_data_rd;
  logic        i2c_ack_error;
  logic [15:0] temp_raw;
  logic        temp_valid;
  logic        err;

  int n_chk = 0;
  int n_fail = 0;
  int n_valid = 0;
  logic [15:0] q[$];

  logic        m_primed = 1'b0;
  logic [15:0] m_h [4];

  temp_poll_sequencer #(
    .SLAVE_ADDR(7'h4B),
    .POLL_CYCLES(P),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .run(run),
    .i2c_ena(i2c_ena),
    .i2c_addr(i2c_addr),
    .i2c_rw(i2c_rw),
    .i2c_busy(i2c_busy),
    .i2c_data_rd(i2c_data_rd),
    .i2c_ack_error(i2c_ack_error),
    .temp_raw(temp_raw),
    .temp_valid(temp_valid),
    .err(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (temp_valid) n_valid++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  // Expected published value for a new good reading.
  function automatic logic [15:0] model(input logic [15:0] r);
`ifdef TEMP_AVG_EN
    logic [17:0] s;
    if (!m_primed) begin
      for (int i = 0; i < 4; i++) m_h[i] = r;
      m_primed = 1'b1;
    end else begin
      for (int i = 3; i > 0; i--) m_h[i] = m_h[i-1];
      m_h[0] = r;
    end
    s = '0;
    for (int i = 0; i < 4; i++) s = s + {{2{m_h[i][15]}}, m_h[i]};
    return s[17:2];
`else
    return r;
`endif
  endfunction

  task automatic wait_ena(input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      if (i2c_ena) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic count_to_ena(output int n);
    n = -1;
    for (int i = 1; i <= 400; i++) begin
      @(negedge clk);
      if (i2c_ena) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic wait_valid(input int lim, output int n);
    n = -1;
    for (int i = 1; i <= lim; i++) begin
      @(negedge clk);
      if (temp_valid) begin
        n = i;
        break;
      end
    end
  endtask

  // Two-byte read as seen from the master; ends having driven the last fall.
  task automatic master_read(input logic [7:0] msb, input logic [7:0] lsb,
                             input bit drop_run,
                             output logic pre, output logic post);
    repeat (2) @(negedge clk);
    i2c_busy = 1'b1;
    repeat (3) @(negedge clk);
    if (drop_run) run = 1'b0;
    i2c_data_rd = msb;
    i2c_busy = 1'b0;
    @(negedge clk);
    pre = i2c_ena;
    i2c_busy = 1'b1;
    @(negedge clk);
    post = i2c_ena;
    repeat (3) @(negedge clk);
    i2c_data_rd = lsb;
    i2c_busy = 1'b0;
  endtask

  task automatic test_reset;
    int n;
    reset_n = 1'b0;
    run = 1'b1;
    i2c_busy = 1'b0;
    i2c_data_rd = 8'h00;
    i2c_ack_error = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++;
    if (i2c_ena !== 1'b0 || temp_valid !== 1'b0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctl: got ena=%b valid=%b err=%b want 0 0 0",
               i2c_ena, temp_valid, err);
    end
    n_chk++;
    if (temp_raw !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_raw: got %h want 0000", temp_raw);
    end
    n_chk++;
    if (i2c_addr !== 7'h4B || i2c_rw !== 1'b1) begin
      n_fail++;
      $display("FAIL addr_rw: got %h/%b want 4b/1", i2c_addr, i2c_rw);
    end
    reset_n = 1'b1;
    count_to_ena(n);
    n_chk++;
    if (n !== P) begin
      n_fail++;
      $display("FAIL first_req: got %0d cycles want %0d", n, P);
    end
  endtask

  task automatic test_normal;
    bit ok;
    int n;
    logic pre, post;
    logic [15:0] e;
    wait_ena(400, ok);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL normal_ena: got no ena want ena");
    end
    q.push_back(model(16'h1980));
    master_read(8'h19, 8'h80, 1'b0, pre, post);
    n_chk++;
    if (pre !== 1'b1 || post !== 1'b0) begin
      n_fail++;
      $display("FAIL ena_drop: got %b->%b want 1->0", pre, post);
    end
    wait_valid(20, n);
    n_chk++;
    if (n !== LAT) begin
      n_fail++;
      $display("FAIL latency: got %0d want %0d", n, LAT);
    end
    e = (q.size() > 0) ? q.pop_front() : 16'hxxxx;
    n_chk++;
    if (temp_raw !== e || err !== 1'b0) begin
      n_fail++;
      $display("FAIL normal_raw: got %h err=%b want %h err=0", temp_raw, err, e);
    end
    @(negedge clk);
    n_chk++;
    if (temp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL valid_width: got %b want 0", temp_valid);
    end
  endtask

  task automatic test_nack;
    bit ok;
    int n, nv0;
    logic pre, post;
    logic [15:0] raw0, e;
    nv0 = n_valid;
    raw0 = temp_raw;
    wait_ena(400, ok);
    repeat (2) @(negedge clk);
    i2c_busy = 1'b1;
    @(negedge clk);
    i2c_ack_error = 1'b1;
    @(negedge clk);
    n_chk++;
    if (i2c_ena !== 1'b0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL nack_ena: got ena=%b err=%b want 0 0", i2c_ena, err);
    end
    @(negedge clk);
    i2c_busy = 1'b0;
    i2c_ack_error = 1'b0;
    @(negedge clk);
    n_chk++;
    if (err !== 1'b1) begin
      n_fail++;
      $display("FAIL nack_err: got %b want 1", err);
    end
    n_chk++;
    if (n_valid !== nv0 || temp_raw !== raw0) begin
      n_fail++;
      $display("FAIL nack_hold: got valids=%0d raw=%h want %0d %h",
               n_valid - nv0, temp_raw, 0, raw0);
    end
    wait_ena(400, ok);
    q.push_back(model(16'h1234));
    master_read(8'h12, 8'h34, 1'b0, pre, post);
    wait_valid(20, n);
    e = (q.size() > 0) ? q.pop_front() : 16'hxxxx;
    n_chk++;
    if (temp_raw !== e || err !== 1'b0 || n !== LAT) begin
      n_fail++;
      $display("FAIL nack_recover: got %h err=%b lat=%0d want %h 0 %0d",
               temp_raw, err, n, e, LAT);
    end
  endtask

  task automatic test_timeout;
    bit ok;
    int n;
    logic pre, post;
    logic [15:0] e;
    wait_ena(400, ok);
    n = -1;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (!i2c_ena) begin
        n = i;
        break;
      end
    end
    n_chk++;
    if (n !== T) begin
      n_fail++;
      $display("FAIL timeout_len: got %0d want %0d", n, T);
    end
    @(negedge clk);
    n_chk++;
    if (err !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_err: got %b want 1", err);
    end
    count_to_ena(n);
    n_chk++;
    if (n !== P) begin
      n_fail++;
      $display("FAIL timeout_resume: got %0d want %0d", n, P);
    end
    q.push_back(model(16'hABCD));
    master_read(8'hAB, 8'hCD, 1'b0, pre, post);
    wait_valid(20, n);
    e = (q.size() > 0) ? q.pop_front() : 16'hxxxx;
    n_chk++;
    if (temp_raw !== e || err !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_recover: got %h err=%b want %h 0", temp_raw, err, e);
    end
  endtask

  task automatic test_run_gating;
    bit ok;
    int n, seen;
    logic pre, post;
    logic [15:0] e;
    wait_ena(400, ok);
    q.push_back(model(16'h0A5F));
    master_read(8'h0A, 8'h5F, 1'b1, pre, post);
    wait_valid(20, n);
    e = (q.size() > 0) ? q.pop_front() : 16'hxxxx;
    n_chk++;
    if (temp_raw !== e || n !== LAT) begin
      n_fail++;
      $display("FAIL gate_finish: got %h lat=%0d want %h %0d", temp_raw, n, e, LAT);
    end
    seen = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (i2c_ena) seen++;
    end
    n_chk++;
    if (seen !== 0) begin
      n_fail++;
      $display("FAIL gate_idle: got %0d ena cycles want 0", seen);
    end
    run = 1'b1;
    count_to_ena(n);
    n_chk++;
    if (n !== P) begin
      n_fail++;
      $display("FAIL gate_restart: got %0d want %0d", n, P);
    end
  endtask

  task automatic test_reset_mid;
    bit ok;
    wait_ena(400, ok);
    repeat (2) @(negedge clk);
    i2c_busy = 1'b1;
    repeat (3) @(negedge clk);
    i2c_data_rd = 8'h77;
    i2c_busy = 1'b0;
    @(negedge clk);
    i2c_busy = 1'b1;
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    n_chk++;
    if (i2c_ena !== 1'b0 || temp_raw !== 16'h0000 ||
        temp_valid !== 1'b0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: got ena=%b raw=%h valid=%b err=%b want 0 0000 0 0",
               i2c_ena, temp_raw, temp_valid, err);
    end
    i2c_busy = 1'b0;
    m_primed = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_back_to_back;
    bit ok;
    int n;
    logic pre, post;
    logic [15:0] e;
    logic [15:0] rd [8];
    rd[0] = 16'h0100; rd[1] = 16'h0200; rd[2] = 16'h0300; rd[3] = 16'h0400;
    rd[4] = 16'hFF00; rd[5] = 16'hFF00; rd[6] = 16'hFF00; rd[7] = 16'hFF00;
    for (int k = 0; k < 8; k++) begin
      wait_ena(400, ok);
      q.push_back(model(rd[k]));
      master_read(rd[k][15:8], rd[k][7:0], 1'b0, pre, post);
      wait_valid(20, n);
      e = (q.size() > 0) ? q.pop_front() : 16'hxxxx;
      n_chk++;
      if (temp_raw !== e || n !== LAT) begin
        n_fail++;
        $display("FAIL b2b_%0d: got %h lat=%0d want %h %0d", k, temp_raw, n, e, LAT);
      end
`ifdef TEMP_AVG_EN
      if (k == 3) begin
        n_chk++;
        if (temp_raw !== 16'h0280) begin
          n_fail++;
          $display("FAIL avg_ramp: got %h want 0280", temp_raw);
        end
      end
`endif
    end
    n_chk++;
    if (temp_raw !== 16'hFF00) begin
      n_fail++;
      $display("FAIL signed_tail: got %h want ff00", temp_raw);
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_nack();
    test_timeout();
    test_run_gating();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
